// File: rtl/wddl_aes_round_ctrl.sv
// Round sequencer for a WDDL (dual-rail) AES datapath: fetches round keys, drives dual-rail text/key rails.
// Optional precharge phase after every LOAD/EVAL is enabled by defining WDDL_AES_PRECHARGE_EN.
module wddl_aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         ready,
    input  logic [127:0] text_in,
    output logic         key_req,
    output logic [3:0]   key_rnd,
    input  logic         key_vld,
    input  logic [127:0] key_w,
    output logic         ld_r,
    output logic [127:0] text_in_r,
    output logic [127:0] text_in_r_n,
    output logic [127:0] w_r,
    output logic [127:0] w_r_n,
    output logic         pre_r,
    input  logic [127:0] sa_q,
    input  logic [127:0] sa_q_n,
    output logic [127:0] text_out,
    output logic         done,
    output logic         rail_err
);

    localparam logic [3:0] NR_L = 4'(NR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_LOAD,
        S_EVAL,
        S_PRE,
        S_DONE
    } state_t;

    state_t       state, state_nxt;
    logic [3:0]   rnd;
    logic [127:0] text_q;
`ifdef WDDL_AES_PRECHARGE_EN
    logic         fin_q;   // last EVAL seen; PRE exits to DONE instead of KEY
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        unique case (state)
            S_IDLE: if (start) state_nxt = S_KEY;
            S_KEY:  if (key_vld) state_nxt = (rnd == 4'd0) ? S_LOAD : S_EVAL;
`ifdef WDDL_AES_PRECHARGE_EN
            S_LOAD: state_nxt = S_PRE;
            S_EVAL: state_nxt = S_PRE;
            S_PRE:  state_nxt = fin_q ? S_DONE : S_KEY;
`else
            S_LOAD: state_nxt = S_KEY;
            S_EVAL: state_nxt = (rnd == NR_L) ? S_DONE : S_KEY;
            S_PRE:  state_nxt = S_IDLE;
`endif
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnd      <= '0;
            text_q   <= '0;
            text_out <= '0;
            rail_err <= 1'b0;
`ifdef WDDL_AES_PRECHARGE_EN
            fin_q    <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: if (start) begin
                    text_q   <= text_in;
                    rnd      <= '0;
                    rail_err <= 1'b0;
`ifdef WDDL_AES_PRECHARGE_EN
                    fin_q    <= 1'b0;
`endif
                end
                S_LOAD: rnd <= rnd + 4'd1;
                S_EVAL: begin
                    if (rnd != NR_L) rnd <= rnd + 4'd1;
`ifdef WDDL_AES_PRECHARGE_EN
                    else             fin_q <= 1'b1;
`endif
                end
                S_DONE: begin
                    text_out <= sa_q;
                    // every bit pair must be complementary; any equal pair flags a fault
                    rail_err <= ((sa_q ^ sa_q_n) != {128{1'b1}});
                end
                default: ;
            endcase
        end
    end

    // Rails are registered on the KEY->LOAD/EVAL edge so they are valid during LOAD/EVAL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            text_in_r   <= '0;
            text_in_r_n <= '0;
            w_r         <= '0;
            w_r_n       <= '0;
        end else if (state == S_KEY && key_vld) begin
            w_r   <= key_w;
            w_r_n <= ~key_w;
            if (rnd == 4'd0) begin
                text_in_r   <= text_q;
                text_in_r_n <= ~text_q;
            end
        end
`ifdef WDDL_AES_PRECHARGE_EN
        else if (state == S_LOAD || state == S_EVAL) begin
            text_in_r   <= '0;
            text_in_r_n <= '0;
            w_r         <= '0;
            w_r_n       <= '0;
        end
`endif
    end

    assign ready   = (state == S_IDLE);
    assign key_req = (state == S_KEY);
    assign key_rnd = rnd;
    assign ld_r    = (state == S_LOAD);
    assign done    = (state == S_DONE);
`ifdef WDDL_AES_PRECHARGE_EN
    assign pre_r   = (state == S_PRE);
`else
    assign pre_r   = 1'b0;
`endif

endmodule

// File: tb/tb_wddl_aes_round_ctrl.sv
// Bench for wddl_aes_round_ctrl: behavioural AES key schedule and dual-rail datapath around the controller,
// expected ciphertexts queued at accept and compared after done.
module tb_wddl_aes_round_ctrl;

    localparam int NR = 10;
`ifdef WDDL_AES_PRECHARGE_EN
    localparam int LAT = 34;
`else
    localparam int LAT = 23;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start = 1'b0;
    logic         ready;
    logic [127:0] text_in = '0;
    logic         key_req;
    logic [3:0]   key_rnd;
    logic         key_vld = 1'b1;
    logic [127:0] key_w;
    logic         ld_r;
    logic [127:0] text_in_r, text_in_r_n, w_r, w_r_n;
    logic         pre_r;
    logic [127:0] sa_q, sa_q_n;
    logic [127:0] text_out;
    logic         done;
    logic         rail_err;

    int total = 0;
    int bad   = 0;
    logic [127:0] sb[$];
    logic [127:0] rk [0:10];
    logic [127:0] dp;
    logic         eval_q;
    logic         corrupt = 1'b0;

    wddl_aes_round_ctrl #(.NR(NR)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready), .text_in(text_in),
        .key_req(key_req), .key_rnd(key_rnd), .key_vld(key_vld), .key_w(key_w),
        .ld_r(ld_r), .text_in_r(text_in_r), .text_in_r_n(text_in_r_n),
        .w_r(w_r), .w_r_n(w_r_n), .pre_r(pre_r), .sa_q(sa_q), .sa_q_n(sa_q_n),
        .text_out(text_out), .done(done), .rail_err(rail_err)
    );

    always #5 clk = ~clk;

    // ---------------- AES reference functions ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        logic [7:0] s = x;
        for (int i = 1; i < 8; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        if (x == 8'h00) r = 8'h00;
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] k, input bit last);
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [7:0] s0, s1, s2, s3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sbox(st[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) b[r+4*c] = a[r+4*((c+r)%4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                s0 = b[4*c]; s1 = b[4*c+1]; s2 = b[4*c+2]; s3 = b[4*c+3];
                b[4*c]   = gmul(8'h02, s0) ^ gmul(8'h03, s1) ^ s2 ^ s3;
                b[4*c+1] = s0 ^ gmul(8'h02, s1) ^ gmul(8'h03, s2) ^ s3;
                b[4*c+2] = s0 ^ s1 ^ gmul(8'h02, s2) ^ gmul(8'h03, s3);
                b[4*c+3] = gmul(8'h03, s0) ^ s1 ^ s2 ^ gmul(8'h02, s3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        return o ^ k;
    endfunction

    task automatic expand_key(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
                rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [127:0] s = pt ^ rk[0];
        for (int r = 1; r <= NR; r++) s = aes_round(s, rk[r], r == NR);
        return s;
    endfunction

    // ---------------- behavioural key schedule and datapath ----------------
    assign key_w  = (key_rnd <= 4'd10) ? rk[key_rnd] : '0;
    assign sa_q   = dp;
    assign sa_q_n = ~dp ^ {127'b0, corrupt};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dp     <= '0;
            eval_q <= 1'b0;
        end else begin
            eval_q <= key_req && key_vld && (key_rnd != 4'd0);
            if (ld_r)        dp <= text_in_r ^ w_r;
            else if (eval_q) dp <= aes_round(dp, w_r, key_rnd == 4'(NR));
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", ready); end
        total++; if ({key_req, ld_r, pre_r, done, rail_err} !== 5'b0) begin
            bad++; $display("FAIL rst_flags got=%b exp=00000", {key_req, ld_r, pre_r, done, rail_err}); end
        total++; if (key_rnd !== 4'd0) begin bad++; $display("FAIL rst_key_rnd got=%0d exp=0", key_rnd); end
        total++; if ({text_in_r, text_in_r_n, w_r, w_r_n, text_out} !== '0) begin
            bad++; $display("FAIL rst_rails got=%h/%h/%h exp=0", text_in_r, w_r, text_out); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Entry and exit: at a negedge with the DUT in IDLE.
    task automatic run_op(input logic [127:0] pt, input logic [127:0] exp_ct, input int stall_len,
                          input bit poke, input bit exp_rerr);
        int  done_cyc = -1;
        int  exp_rnd  = 0;
        int  stalls   = stall_len;
        int  ld_cnt   = 0;
        int  ld_cyc   = -1;
        int  pre_cnt  = 0;
        bit  rails_live = 1'b0;
        bit  stalled_prev = 1'b0;
        bit  prev_eval = 1'b0;
        logic [127:0] got_ct;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL ready_before_start got=%b exp=1", ready); end
        text_in = pt;
        start   = 1'b1;
        key_vld = 1'b1;
        sb.push_back(exp_ct);
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 200 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                total++; if (ready !== 1'b0) begin bad++; $display("FAIL ready_drop got=%b exp=0", ready); end
                total++; if (rail_err !== 1'b0) begin bad++; $display("FAIL rail_err_clear got=%b exp=0", rail_err); end
            end
            start = poke && (cyc == 6);
            if (stalled_prev) begin
                total++; if (key_req !== 1'b1 || key_rnd !== 4'd5) begin
                    bad++; $display("FAIL stall_hold got=%b/%0d exp=1/5", key_req, key_rnd); end
            end
            key_vld = 1'b1;
            stalled_prev = 1'b0;
            if (key_req === 1'b1 && key_rnd === 4'd5 && stalls > 0) begin
                key_vld = 1'b0;
                stalls--;
                stalled_prev = 1'b1;
            end
            if (key_req === 1'b1) begin
                total++; if (key_rnd !== 4'(exp_rnd)) begin
                    bad++; $display("FAIL key_rnd_seq got=%0d exp=%0d", key_rnd, exp_rnd); end
                if (key_vld) exp_rnd++;
            end
            if (ld_r === 1'b1) begin
                ld_cnt++;
                ld_cyc = cyc;
                rails_live = 1'b1;
                total++; if (text_in_r !== pt || text_in_r_n !== ~pt) begin
                    bad++; $display("FAIL load_text got=%h exp=%h", text_in_r, pt); end
            end
`ifdef WDDL_AES_PRECHARGE_EN
            if (pre_r === 1'b1) begin
                pre_cnt++;
                total++; if ({text_in_r, text_in_r_n, w_r, w_r_n} !== '0) begin
                    bad++; $display("FAIL pre_rails got=%h/%h exp=0", text_in_r, w_r); end
            end
            if (key_req === 1'b1) begin
                total++; if ({text_in_r, text_in_r_n, w_r, w_r_n} !== '0) begin
                    bad++; $display("FAIL key_rails got=%h/%h exp=0", text_in_r, w_r); end
            end
            total++; if (eval_q && prev_eval) begin bad++; $display("FAIL eval_adjacent at cycle %0d", cyc); end
            prev_eval = eval_q;
`else
            total++; if (pre_r !== 1'b0) begin bad++; $display("FAIL pre_r_off got=%b exp=0", pre_r); end
            if (rails_live) begin
                total++; if (w_r_n !== ~w_r || text_in_r_n !== ~text_in_r) begin
                    bad++; $display("FAIL rail_compl got=%h exp=%h", w_r_n, ~w_r); end
            end
`endif
            if (done === 1'b1) begin
                done_cyc = cyc;
                if (poke) start = 1'b1;
            end
        end
        total++; if (done_cyc != LAT + stall_len) begin
            bad++; $display("FAIL done_latency got=%0d exp=%0d", done_cyc, LAT + stall_len); end
        total++; if (ld_cnt != 1 || ld_cyc != 2) begin
            bad++; $display("FAIL ld_pulse got=%0d@%0d exp=1@2", ld_cnt, ld_cyc); end
        total++; if (exp_rnd != NR + 1) begin bad++; $display("FAIL key_count got=%0d exp=%0d", exp_rnd, NR + 1); end
`ifdef WDDL_AES_PRECHARGE_EN
        total++; if (pre_cnt != NR + 1) begin bad++; $display("FAIL pre_count got=%0d exp=%0d", pre_cnt, NR + 1); end
`endif
        @(negedge clk);
        total++; if (done !== 1'b0 || ready !== 1'b1) begin
            bad++; $display("FAIL done_single got=%b/%b exp=0/1", done, ready); end
        got_ct = sb.pop_front();
        total++; if (text_out !== got_ct) begin bad++; $display("FAIL text_out got=%h exp=%h", text_out, got_ct); end
        total++; if (rail_err !== exp_rerr) begin bad++; $display("FAIL rail_err got=%b exp=%b", rail_err, exp_rerr); end
    endtask

    task automatic test_basic();
        run_op(128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        logic [127:0] pt = {$urandom, $urandom, $urandom, $urandom};
        run_op(pt, aes_enc(pt), 3, 1'b0, 1'b0);
    endtask

    task automatic test_rail_err();
        logic [127:0] pt = {$urandom, $urandom, $urandom, $urandom};
        corrupt = 1'b1;
        run_op(pt, aes_enc(pt), 0, 1'b0, 1'b1);
        corrupt = 1'b0;
        pt = {$urandom, $urandom, $urandom, $urandom};
        run_op(pt, aes_enc(pt), 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [127:0] pt1 = 128'hffffffffffffffffffffffffffffffff;
        logic [127:0] pt2 = 128'h0;
        run_op(pt1, aes_enc(pt1), 0, 1'b1, 1'b0);
        run_op(pt2, aes_enc(pt2), 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int found = 0;
        int dones = 0;
        text_in = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        start   = 1'b1;
        key_vld = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk);
            if (eval_q === 1'b1 && key_rnd === 4'd4) found = 1;
        end
        total++; if (found != 1) begin bad++; $display("FAIL reach_eval4 got=%0d exp=1", found); end
        rst = 1'b1;
        #1;
        total++; if (ready !== 1'b1 || {key_req, ld_r, pre_r, done, rail_err} !== 5'b0 || key_rnd !== 4'd0) begin
            bad++; $display("FAIL async_rst_ctrl got=%b/%b/%0d exp=1/00000/0", ready,
                            {key_req, ld_r, pre_r, done, rail_err}, key_rnd); end
        total++; if ({text_in_r, text_in_r_n, w_r, w_r_n, text_out} !== '0) begin
            bad++; $display("FAIL async_rst_data got=%h/%h/%h exp=0", text_in_r, w_r, text_out); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL no_done_after_rst got=%0d exp=0", dones); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL idle_after_rst got=%b exp=1", ready); end
    endtask

    initial begin
        expand_key(128'h000102030405060708090a0b0c0d0e0f);
        test_reset();
        test_basic();
        test_stall();
        test_rail_err();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wddl_aes_round_ctrl.md
WDDL_AES_ROUND_CTRL -- requirements
Module: wddl_aes_round_ctrl

Interface
REQ-001 Parameter NR, default 10, number of AES rounds after the initial AddRoundKey (legal 10/12/14).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  request to encrypt text_in; accepted only when start && ready.
REQ-005 ready  out  1  high exactly when the FSM is in IDLE.
REQ-006 text_in  in  128  plaintext, sampled on start acceptance.
REQ-007 key_req  out  1  round-key request to the key schedule.
REQ-008 key_rnd  out  4  index of the requested round key, 0..NR.
REQ-009 key_vld  in  1  key schedule has key_w valid for key_rnd.
REQ-010 key_w  in  128  round key {w0,w1,w2,w3}, w0 in [127:96].
REQ-011 ld_r  out  1  datapath load strobe (initial round).
REQ-012 text_in_r / text_in_r_n  out  128 each  dual-rail plaintext to the datapath.
REQ-013 w_r / w_r_n  out  128 each  dual-rail round key to the datapath (w0..w3 and w0_n..w3_n).
REQ-014 pre_r  out  1  precharge-phase indicator.
REQ-015 sa_q / sa_q_n  in  128 each  dual-rail datapath state {sa00,sa10,sa20,sa30,sa01,...,sa33}, sa00 in [127:120].
REQ-016 text_out  out  128  ciphertext captured from sa_q.
REQ-017 done  out  1  one-cycle completion pulse.
REQ-018 rail_err  out  1  dual-rail integrity flag for the last result.

Function
REQ-019 States: IDLE, KEY, LOAD, EVAL, PRE (PRE only with the macro), DONE.
REQ-020 IDLE: on start && ready, capture text_in, set rnd=0, clear rail_err, go to KEY; start is ignored in all other states.
REQ-021 KEY: key_req=1, key_rnd=rnd held stable; on key_vld (including in the same cycle as key_req) capture key_w and go to LOAD if rnd==0, else EVAL.
REQ-022 LOAD (1 cycle): ld_r=1; text_in_r=captured text, text_in_r_n=~text; w_r=key, w_r_n=~key; then rnd+=1 and go to KEY (PRE first if the macro is defined).
REQ-023 EVAL (1 cycle): w_r=key, w_r_n=~key, ld_r=0; if rnd==NR go to DONE (through PRE with the macro), else rnd+=1 and go to KEY (through PRE with the macro).
REQ-024 DONE (1 cycle): done=1; text_out<=sa_q; rail_err<=(sa_q ^ sa_q_n) != all-ones; go to IDLE.
REQ-025 ld_r and done are single-cycle pulses; key_rnd sequence per operation is exactly 0,1,...,NR.
REQ-026 With key_vld tied high: done asserts 23 cycles after the accept cycle (NR=10, macro off) or 34 cycles (macro on); each key_vld stall cycle adds exactly one cycle.
REQ-027 text_out and rail_err hold until the DONE state of the next operation or reset.

Reset
REQ-028 rst asserted in any state, including mid-round, forces IDLE asynchronously and discards the operation; no done pulse is issued.
REQ-029 Reset values: ready=1; key_req, ld_r, pre_r, done, rail_err=0; key_rnd=0; all rail outputs and text_out=0.

Configuration
REQ-030 Macro WDDL_AES_PRECHARGE_EN defined: a PRE state follows every LOAD and EVAL; in PRE, pre_r=1 and both rails of text_in_r and w_r are driven to 0. In IDLE, KEY, and DONE, all rails are also 0.
REQ-031 Macro not defined: no PRE state and pre_r is tied to 0; rail outputs hold their last LOAD/EVAL values outside LOAD/EVAL, with the _n rails always equal to the complement of the true rails.

Verification
REQ-032 key_vld=1, text_in=0x00112233445566778899aabbccddeeff -> ld_r pulses once in cycle 2; key_rnd walks 0..10; done at cycle 23 (off) or 34 (on); text_out equals the reference-model ciphertext.
REQ-033 key_vld withheld 3 cycles at rnd=5 -> key_req stays high with key_rnd=5 stable, there is no EVAL during the stall, and done arrives 3 cycles later.
REQ-034 start pulsed while busy and in DONE -> ignored; a start in the cycle after done is accepted, and ready drops the next cycle.
REQ-035 sa_q_n=~sa_q except bit 0 equal -> rail_err=1 after done; the next start clears rail_err.
REQ-036 rst asserted during EVAL of round 4 -> outputs reach their REQ-029 values without a clock edge, and no done pulse follows.
REQ-037 Macro on -> every PRE cycle has pre_r=1, text_in_r, text_in_r_n, w_r, and w_r_n all 0, and no two EVAL cycles are adjacent.
